cap_trig_ctrl: RTL and testbench

Capture controller directly downstream of the protocol trigger unit. Combines protTrig with per-channel triggers under an enable mask. Runs the pre-trigger / armed / post-trigger state machine that drives the sample RAM write port as a circular buffer. Reports completion and the trigger location for the dump engine.

---
 rtl/cap_pkg.sv | 23 ++
 rtl/trig_src_comb.sv | 30 +++
 rtl/cap_trig_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cap_trig_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cap_pkg.sv
// Shared types and constants for the capture trigger controller.
// The trigger-enable vector carries the protocol trigger in its top bit.
package cap_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_NCH    = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit position of protTrig inside trig_en for a given channel count
    function automatic int prot_idx(input int nch);
        return nch;
    endfunction

    localparam int PROT_IDX = prot_idx(DEF_NCH);

endpackage

// File: rtl/trig_src_comb.sv
// Masked AND of the protocol and channel trigger sources.
// Disabled sources are forced true; an all-zero mask never fires.
module trig_src_comb
    import cap_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic           prot_trig_i,
    input  logic [NCH-1:0] ch_trig_i,
    input  logic [NCH:0]   trig_en_i,
    output logic           trig_hit_o
);

    localparam int PROT_BIT = prot_idx(NCH);

    logic [NCH:0] src;
    logic [NCH:0] pass;

    assign src[PROT_BIT]  = prot_trig_i;
    assign src[NCH-1:0]   = ch_trig_i;

    generate
        for (genvar gi = 0; gi <= NCH; gi++) begin : g_pass
            assign pass[gi] = src[gi] | ~trig_en_i[gi];
        end
    endgenerate

    assign trig_hit_o = (|trig_en_i) & (&pass);

endmodule

// File: rtl/cap_trig_ctrl.sv
// Pre-trigger / armed / post-trigger capture sequencer driving the sample RAM
// write port as a circular buffer of DEPTH = 2**ADDR_W samples.
module cap_trig_ctrl
    import cap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NCH    = DEF_NCH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              smpl_en,
    input  logic              protTrig,
    input  logic [NCH-1:0]    chTrig,
    input  logic [NCH:0]      trig_en,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we_ram,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_base
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]   trig_pos_q, trig_pos_d;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
    logic                armed_q, armed_d;
    logic                triggered_q, triggered_d;
    logic                done_q, done_d;

    logic                trig_hit;
    logic                capturing;
    logic                wr;
    logic [ADDR_W-1:0]   waddr_inc;
    logic [ADDR_W-1:0]   pre_thr;

    trig_src_comb #(
        .NCH (NCH)
    ) u_trig_src (
        .prot_trig_i (protTrig),
        .ch_trig_i   (chTrig),
        .trig_en_i   (trig_en),
        .trig_hit_o  (trig_hit)
    );

    assign capturing = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign wr        = smpl_en & capturing;
    assign waddr_inc = waddr_q + 1'b1;
    // (DEPTH-1) - trig_pos in ADDR_W bits is just the bitwise complement
    assign pre_thr   = ~trig_pos_q;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_pos_d  = trig_pos_q;
        trig_addr_d = trig_addr_q;
        rd_base_d   = rd_base_q;
        armed_d     = armed_q;
        triggered_d = triggered_q;
        done_d      = done_q;

        if (wr) begin
            waddr_d = waddr_inc;
        end

        if (abort) begin
            state_d     = IDLE;
            armed_d     = 1'b0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d     = PRE;
                        waddr_d     = '0;
                        pre_cnt_d   = '0;
                        post_cnt_d  = '0;
                        trig_pos_d  = trig_pos;
                        armed_d     = 1'b0;
                        triggered_d = 1'b0;
                        done_d      = 1'b0;
                    end
                end
                PRE: begin
                    if (pre_thr == '0) begin
                        state_d = ARMED;
                        armed_d = 1'b1;
                    end else if (wr) begin
                        if (pre_cnt_q == pre_thr - 1'b1) begin
                            state_d = ARMED;
                            armed_d = 1'b1;
                        end else begin
                            pre_cnt_d = pre_cnt_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (wr && trig_hit) begin
                        trig_addr_d = waddr_q;
                        triggered_d = 1'b1;
                        armed_d     = 1'b0;
                        post_cnt_d  = '0;
                        if (trig_pos_q == '0) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            rd_base_d = waddr_inc;
                        end else begin
                            state_d = POST;
                        end
                    end
                end
                POST: begin
                    if (wr) begin
                        if (post_cnt_q == trig_pos_q - 1'b1) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            rd_base_d = waddr_inc;
                        end else begin
                            post_cnt_d = post_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_pos_q  <= '0;
            trig_addr_q <= '0;
            rd_base_q   <= '0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_pos_q  <= trig_pos_d;
            trig_addr_q <= trig_addr_d;
            rd_base_q   <= rd_base_d;
            armed_q     <= armed_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    assign we_ram       = wr;
    assign waddr        = waddr_q;
    assign armed        = armed_q;
    assign triggered    = triggered_q;
    assign capture_done = done_q;
    assign trig_addr    = trig_addr_q;
    assign rd_base      = rd_base_q;

endmodule

// File: tb/tb_cap_trig_ctrl.sv
// Directed bench for cap_trig_ctrl at ADDR_W=4 (DEPTH=16), NCH=5.
// Expected values are hand-computed from the capture timeline.
module tb_cap_trig_ctrl;

    localparam int ADDR_W = 4;
    localparam int NCH    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              smpl_en;
    logic              protTrig;
    logic [NCH-1:0]    chTrig;
    logic [NCH:0]      trig_en;
    logic [ADDR_W-1:0] trig_pos;
    logic              we_ram;
    logic [ADDR_W-1:0] waddr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] rd_base;

    int n_assert = 0;
    int n_fail   = 0;
    int writes   = 0;
    int ph       = 0;

    cap_trig_ctrl #(
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .smpl_en      (smpl_en),
        .protTrig     (protTrig),
        .chTrig       (chTrig),
        .trig_en      (trig_en),
        .trig_pos     (trig_pos),
        .we_ram       (we_ram),
        .waddr        (waddr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .trig_addr    (trig_addr),
        .rd_base      (rd_base)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_we"},    {31'd0, we_ram},       32'd0);
        chk({pfx, "_waddr"}, {28'd0, waddr},        32'd0);
        chk({pfx, "_armed"}, {31'd0, armed},        32'd0);
        chk({pfx, "_trig"},  {31'd0, triggered},    32'd0);
        chk({pfx, "_done"},  {31'd0, capture_done}, 32'd0);
        chk({pfx, "_taddr"}, {28'd0, trig_addr},    32'd0);
        chk({pfx, "_rdb"},   {28'd0, rd_base},      32'd0);
    endtask

    // One cycle of the 1-in-4 strobe pattern, counting RAM writes
    task automatic step(input logic pt);
        smpl_en  = (ph == 0);
        protTrig = pt;
        #1;
        if (we_ram) writes++;
        @(posedge clk);
        #1;
        protTrig = 1'b0;
        ph = (ph + 1) % 4;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; smpl_en = 1'b0;
        protTrig = 1'b0; chTrig = '0; trig_en = '0; trig_pos = '0;
        tick(); tick();
        chk_zero("reset");
        rst_n = 1'b1;

        // Test 1: trig_pos=4, protTrig only
        smpl_en = 1'b1; trig_pos = 4'd4; trig_en = 6'b100000;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_we_pre", {31'd0, we_ram}, 32'd1);
        chk("t1_waddr0", {28'd0, waddr}, 32'd0);
        repeat (10) tick();
        chk("t1_not_armed", {31'd0, armed}, 32'd0);
        tick();
        chk("t1_armed", {31'd0, armed}, 32'd1);
        chk("t1_waddr11", {28'd0, waddr}, 32'd11);
        repeat (9) tick();
        chk("t1_wrap4", {28'd0, waddr}, 32'd4);
        protTrig = 1'b1; tick(); protTrig = 1'b0;
        chk("t1_trig", {31'd0, triggered}, 32'd1);
        chk("t1_disarm", {31'd0, armed}, 32'd0);
        chk("t1_taddr", {28'd0, trig_addr}, 32'd4);
        repeat (3) tick();
        chk("t1_not_done", {31'd0, capture_done}, 32'd0);
        tick();
        chk("t1_done", {31'd0, capture_done}, 32'd1);
        chk("t1_rdbase", {28'd0, rd_base}, 32'd9);
        chk("t1_we_done", {31'd0, we_ram}, 32'd0);
        tick();
        chk("t1_sticky", {31'd0, capture_done}, 32'd1);

        // Test 2: trig_pos=0, two channel triggers held high
        trig_pos = 4'd0; trig_en = 6'b000011; chTrig = 5'b00011;
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_done_clr", {31'd0, capture_done}, 32'd0);
        repeat (15) tick();
        chk("t2_armed", {31'd0, armed}, 32'd1);
        chk("t2_waddr15", {28'd0, waddr}, 32'd15);
        chk("t2_no_trig_pre", {31'd0, triggered}, 32'd0);
        tick();
        chk("t2_done", {31'd0, capture_done}, 32'd1);
        chk("t2_trig", {31'd0, triggered}, 32'd1);
        chk("t2_taddr", {28'd0, trig_addr}, 32'd15);
        chk("t2_rdbase", {28'd0, rd_base}, 32'd0);

        // Test 3: protTrig AND chTrig[0] required
        chTrig = '0; trig_en = 6'b100001; trig_pos = 4'd4;
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        chk("t3_armed", {31'd0, armed}, 32'd1);
        protTrig = 1'b1; tick(); protTrig = 1'b0;
        chk("t3_partial_no_trig", {31'd0, triggered}, 32'd0);
        chk("t3_waddr12", {28'd0, waddr}, 32'd12);
        repeat (5) tick();
        chk("t3_wrap1", {28'd0, waddr}, 32'd1);
        chk("t3_still_armed", {31'd0, armed}, 32'd1);
        protTrig = 1'b1; chTrig = 5'b00001; tick(); protTrig = 1'b0; chTrig = '0;
        chk("t3_trig", {31'd0, triggered}, 32'd1);
        chk("t3_taddr", {28'd0, trig_addr}, 32'd1);
        repeat (4) tick();
        chk("t3_done", {31'd0, capture_done}, 32'd1);
        chk("t3_rdbase", {28'd0, rd_base}, 32'd6);

        // Test 4: strobe every 4th cycle, trig_pos=8
        trig_pos = 4'd8; trig_en = 6'b100000; smpl_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_we_nostrobe", {31'd0, we_ram}, 32'd0);
        smpl_en = 1'b1; #1;
        chk("t4_we_strobe", {31'd0, we_ram}, 32'd1);
        smpl_en = 1'b0; #1;
        ph = 0; writes = 0;
        for (int i = 0; i < 200 && !armed; i++) step(1'b0);
        chk("t4_armed", {31'd0, armed}, 32'd1);
        chk("t4_waddr7", {28'd0, waddr}, 32'd7);
        chk("t4_prewrites", writes, 32'd7);
        chk("t4_phase", ph, 32'd1);
        step(1'b1);
        chk("t4_trig_ignored", {31'd0, triggered}, 32'd0);
        for (int i = 0; i < 8 && ph != 0; i++) step(1'b0);
        step(1'b1);
        chk("t4_trig", {31'd0, triggered}, 32'd1);
        chk("t4_taddr", {28'd0, trig_addr}, 32'd7);
        for (int i = 0; i < 200 && !capture_done; i++) step(1'b0);
        chk("t4_done", {31'd0, capture_done}, 32'd1);
        chk("t4_writes", writes, 32'd16);
        chk("t4_rdbase", {28'd0, rd_base}, 32'd0);

        // Test 5: abort in POST, then start+abort from DONE
        smpl_en = 1'b1; trig_pos = 4'd4; trig_en = 6'b100000;
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        protTrig = 1'b1; tick(); protTrig = 1'b0;
        chk("t5_trig", {31'd0, triggered}, 32'd1);
        tick(); tick();
        chk("t5_waddr14", {28'd0, waddr}, 32'd14);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_abort_trig", {31'd0, triggered}, 32'd0);
        chk("t5_abort_done", {31'd0, capture_done}, 32'd0);
        chk("t5_abort_armed", {31'd0, armed}, 32'd0);
        chk("t5_abort_we", {31'd0, we_ram}, 32'd0);
        chk("t5_taddr_held", {28'd0, trig_addr}, 32'd11);
        trig_pos = 4'd0; trig_en = 6'b000011; chTrig = 5'b00011;
        start = 1'b1; tick(); start = 1'b0;
        repeat (16) tick();
        chk("t5_done", {31'd0, capture_done}, 32'd1);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("t5_sa_done", {31'd0, capture_done}, 32'd0);
        chk("t5_sa_we", {31'd0, we_ram}, 32'd0);
        chk("t5_rdb_held", {28'd0, rd_base}, 32'd0);
        tick();
        chk("t5_stay_idle", {31'd0, we_ram}, 32'd0);

        // Test 6: empty mask never triggers; reset while ARMED
        trig_en = '0; chTrig = 5'b11111; protTrig = 1'b1; trig_pos = 4'd4;
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        chk("t6_armed", {31'd0, armed}, 32'd1);
        repeat (30) tick();
        chk("t6_still_armed", {31'd0, armed}, 32'd1);
        chk("t6_no_trig", {31'd0, triggered}, 32'd0);
        chk("t6_waddr9", {28'd0, waddr}, 32'd9);
        rst_n = 1'b0; tick();
        chk_zero("t6_rst");
        rst_n = 1'b1; protTrig = 1'b0; chTrig = '0;

        // Boundary: trig_pos = DEPTH-1 arms after one PRE cycle
        trig_pos = 4'd15; trig_en = 6'b100000;
        start = 1'b1; tick(); start = 1'b0;
        chk("b_not_armed", {31'd0, armed}, 32'd0);
        tick();
        chk("b_armed", {31'd0, armed}, 32'd1);
        chk("b_waddr1", {28'd0, waddr}, 32'd1);
        protTrig = 1'b1; tick(); protTrig = 1'b0;
        chk("b_trig", {31'd0, triggered}, 32'd1);
        chk("b_taddr", {28'd0, trig_addr}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
